// File: rtl/des_sign_ctrl.sv
// DES-CBC signing controller: chains message blocks through an external DES core,
// forwards ciphertexts to a serializer and hands the final partial block over separately.
module des_sign_ctrl #(
  parameter logic [63:0] IV    = 64'h0000_0000_0000_0000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [63:0]      blk_in,
  input  logic             blk_valid,
  input  logic             blk_last,
  input  logic [5:0]       blk_size,
  output logic             blk_ready,
  output logic [63:0]      des_data,
  output logic             des_start,
  input  logic             des_busy,
  input  logic [63:0]      des_out,
  output logic [63:0]      ser_des_in,
  output logic             ser_des_wr,
  output logic [63:0]      last_in,
  output logic [5:0]       last_size,
  output logic             last_filled,
  input  logic             last_ack,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned SIZE_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_LASTW = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [BLK_W-1:0]   chain;
  logic               accept;

  assign blk_ready = (state == S_IDLE) & clk_en;
  assign accept    = blk_valid & blk_ready;

  // State register; clk_en freezes the FSM in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Next state and single-cycle strobes; strobes are suppressed while frozen or in reset.
  always_comb begin
    state_nxt  = state;
    des_start  = 1'b0;
    ser_des_wr = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = blk_last ? S_LASTW : S_START;
        end
      end
      S_START: begin
        des_start = clk_en & ~rst;
        state_nxt = S_ARM;
      end
      S_ARM: begin
        if (des_busy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!des_busy) begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        ser_des_wr = clk_en & ~rst;
        state_nxt  = S_IDLE;
      end
      S_LASTW: begin
        if (last_ack) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done      = clk_en & ~rst;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. The DES result is captured as busy falls so that ser_des_in is
  // already valid during the ser_des_wr cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      des_data    <= '0;
      ser_des_in  <= '0;
      last_in     <= '0;
      last_size   <= SIZE_W'(0);
      last_filled <= 1'b0;
      chain       <= IV;
      blk_cnt     <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (blk_last) begin
              last_in     <= blk_in;
              last_size   <= blk_size;
              last_filled <= 1'b1;
            end else begin
              des_data <= blk_in ^ chain;
            end
          end
        end
        S_WAIT: begin
          if (!des_busy) begin
            ser_des_in <= des_out;
            chain      <= des_out;
          end
        end
        S_EMIT: begin
          if (blk_cnt != CNT_MAX) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
          end
        end
        S_LASTW: begin
          if (last_ack) begin
            last_filled <= 1'b0;
          end
        end
        S_FIN: begin
          chain   <= IV;
          blk_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sign_ctrl.sv
// Scoreboard bench for des_sign_ctrl: CBC reference model in the driver, a DES core stub,
// and a monitor that checks every strobe the DUT emits.
module tb_des_sign_ctrl;

  localparam logic [63:0] TB_IV = 64'h0;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_en = 1'b1;
  logic [63:0]      blk_in = '0;
  logic             blk_valid = 1'b0;
  logic             blk_last = 1'b0;
  logic [5:0]       blk_size = '0;
  logic             blk_ready;
  logic [63:0]      des_data;
  logic             des_start;
  logic             des_busy = 1'b0;
  logic [63:0]      des_out = '0;
  logic [63:0]      ser_des_in;
  logic             ser_des_wr;
  logic [63:0]      last_in;
  logic [5:0]       last_size;
  logic             last_filled;
  logic             last_ack = 1'b0;
  logic             done;
  logic [CNT_W-1:0] blk_cnt;

  des_sign_ctrl #(.IV(TB_IV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .blk_in(blk_in), .blk_valid(blk_valid), .blk_last(blk_last), .blk_size(blk_size),
    .blk_ready(blk_ready),
    .des_data(des_data), .des_start(des_start), .des_busy(des_busy), .des_out(des_out),
    .ser_des_in(ser_des_in), .ser_des_wr(ser_des_wr),
    .last_in(last_in), .last_size(last_size), .last_filled(last_filled), .last_ack(last_ack),
    .done(done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] p;
    logic [63:0] c;
    logic [31:0] cnt;
  } wr_t;

  typedef struct packed {
    logic        has;
    logic [63:0] v;
  } ovr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] start_q[$];
  wr_t         wr_q[$];
  int          done_q[$];
  ovr_t        ovr_q[$];

  logic [63:0] m_chain = TB_IV;
  int          m_cnt = 0;

  int en_mode = 0;
  int ack_mode = 1;
  int stub_len_force = 0;
  int stub_dly_force = -1;
  bit lat_check = 1'b0;

  bit          stub_pend = 1'b0;
  int          stub_dly = 0;
  int          stub_cnt = 0;
  logic [63:0] stub_val = '0;
  int          start_evt = 0;
  int          start_ack = 0;
  logic [63:0] start_data = '0;

  bit          acc_seen = 1'b0;
  bit          in_flight = 1'b0;
  bit          chk_zero = 1'b0;
  bit          chk_cnt = 1'b0;
  int          exp_cnt_next = 0;
  int          lat_start = 0;
  wr_t         mon_e;
  ovr_t        stub_o;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Stand-in for the DES cipher: any fixed bijection-like scramble is enough here.
  function automatic logic [63:0] des_fn(input logic [63:0] x);
    return {x[40:0], x[63:41]} ^ 64'hC3A5_5A3C_0F0F_F0F0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen or bound expired at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  // Environment: clk_en pattern, last_ack policy and DES core behaviour (+2 after each edge).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (des_busy && clk_en && stub_cnt > 0) stub_cnt--;
      if (des_busy && stub_cnt == 0) begin
        des_busy = 1'b0;
        des_out  = stub_val;
      end else if (des_busy) begin
        des_out = rnd64();
      end
      if (start_evt != start_ack) begin
        start_ack = start_evt;
        stub_o    = (ovr_q.size() > 0) ? ovr_q.pop_front() : '0;
        stub_val  = stub_o.has ? stub_o.v : des_fn(start_data);
        stub_pend = 1'b1;
        stub_dly  = (stub_dly_force >= 0) ? stub_dly_force : $urandom_range(0, 2);
      end
      if (stub_pend) begin
        if (stub_dly == 0) begin
          des_busy  = 1'b1;
          stub_cnt  = (stub_len_force > 0) ? stub_len_force : $urandom_range(1, 6);
          stub_pend = 1'b0;
          des_out   = rnd64();
        end else begin
          stub_dly--;
        end
      end
      case (en_mode)
        0:       clk_en = 1'b1;
        1:       clk_en = 1'($urandom_range(0, 1));
        default: clk_en = ~clk_en;
      endcase
      case (ack_mode)
        0:       last_ack = ($urandom_range(0, 7) == 0);
        1:       last_ack = 1'b0;
        default: last_ack = 1'b1;
      endcase
    end
  end

  // Monitor: samples at +6, pops the scoreboard on every DUT strobe.
  initial begin
    forever begin
      @(posedge clk);
      #6;
      cyc++;
      if (rst) begin
        chk("reset_pulses", 64'({des_start, ser_des_wr, done}), 64'd0);
        in_flight = 1'b0;
        chk_zero  = 1'b0;
        chk_cnt   = 1'b0;
      end else begin
        if (chk_zero) chk("blk_cnt_cleared", 64'(blk_cnt), 64'd0);
        chk_zero = 1'b0;
        if (chk_cnt) chk("blk_cnt_after_emit", 64'(blk_cnt), 64'(exp_cnt_next));
        chk_cnt = 1'b0;
        if (!clk_en) chk("frozen_strobes", 64'({blk_ready, des_start, ser_des_wr, done}), 64'd0);
        if (in_flight) chk("blk_ready_busy", 64'(blk_ready), 64'd0);
        if (blk_valid && blk_ready) begin
          acc_seen  = 1'b1;
          in_flight = 1'b1;
          if (lat_check && !blk_last) lat_start = cyc;
        end
        if (des_start) begin
          if (start_q.size() == 0) fail_evt("unexpected_des_start");
          else chk("des_data", des_data, start_q.pop_front());
          start_data = des_data;
          start_evt++;
        end
        if (ser_des_wr) begin
          if (wr_q.size() == 0) begin
            fail_evt("unexpected_ser_des_wr");
          end else begin
            mon_e = wr_q.pop_front();
            chk("des_data_hold", des_data, mon_e.p);
            chk("ser_des_in", ser_des_in, mon_e.c);
            chk_cnt      = 1'b1;
            exp_cnt_next = int'(mon_e.cnt);
            if (lat_check) chk("latency", 64'(cyc - lat_start), 64'(3 + stub_len_force));
          end
          in_flight = 1'b0;
        end
        if (done) begin
          if (done_q.size() == 0) fail_evt("unexpected_done");
          else chk("done_blk_cnt", 64'(blk_cnt), 64'(done_q.pop_front()));
          chk_zero  = 1'b1;
          in_flight = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [63:0] b, input logic lst, input logic [5:0] sz);
    int n;
    n = 0;
    blk_in    = b;
    blk_last  = lst;
    blk_size  = sz;
    blk_valid = 1'b1;
    acc_seen  = 1'b0;
    step();
    while (!acc_seen && n < 3000) begin
      step();
      n++;
    end
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    blk_in    = rnd64();
    blk_size  = 6'($urandom_range(0, 63));
    if (!acc_seen) fail_evt("accept_timeout");
  endtask

  // CBC reference: plaintext = block XOR previous ciphertext (IV at message start).
  task automatic send_full(input logic [63:0] b, input logic has_ovr, input logic [63:0] ovr);
    logic [63:0] p;
    logic [63:0] c;
    p = b ^ m_chain;
    c = has_ovr ? ovr : des_fn(p);
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    start_q.push_back(p);
    wr_q.push_back('{p: p, c: c, cnt: 32'(m_cnt)});
    ovr_q.push_back('{has: has_ovr, v: ovr});
    m_chain = c;
    send(b, 1'b0, 6'd0);
  endtask

  task automatic send_last(input logic [63:0] b, input logic [5:0] sz, input int hold);
    int n;
    ack_mode = 1;
    done_q.push_back(m_cnt);
    send(b, 1'b1, sz);
    m_chain = TB_IV;
    m_cnt   = 0;
    for (int k = 0; k < hold; k++) begin
      chk("last_filled_held", 64'(last_filled), 64'd1);
      chk("last_in", last_in, b);
      chk("last_size", 64'(last_size), 64'(sz));
      step();
    end
    ack_mode = 2;
    n = 0;
    while (last_filled && n < 3000) begin
      step();
      n++;
    end
    if (last_filled) fail_evt("last_ack_timeout");
    ack_mode = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_strobes", 64'({des_start, ser_des_wr, done}), 64'd0);
    chk("rst_last_filled", 64'(last_filled), 64'd0);
    chk("rst_des_data", des_data, 64'd0);
    chk("rst_ser_des_in", ser_des_in, 64'd0);
    chk("rst_last_in", last_in, 64'd0);
    chk("rst_last_size", 64'(last_size), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
  endtask

  task automatic reset_in_wait();
    int n;
    stub_len_force = 20;
    stub_dly_force = 0;
    send_full(rnd64(), 1'b0, 64'd0);
    n = 0;
    while (!des_busy && n < 100) begin
      step();
      n++;
    end
    if (!des_busy) fail_evt("busy_timeout");
    repeat (3) step();
    rst = 1'b1;
    wr_q.delete();
    m_chain = TB_IV;
    m_cnt   = 0;
    step();
    rst = 1'b0;
    chk_reset_vals();
    chk("rst_ready", 64'(blk_ready), 64'(clk_en));
    stub_len_force = 0;
    stub_dly_force = -1;
    n = 0;
    while ((des_busy || stub_pend) && n < 100) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  initial begin
    repeat (3) step();
    chk_reset_vals();
    rst = 1'b0;
    ack_mode = 0;
    step();
    chk("idle_ready", 64'(blk_ready), 64'd1);

    // Single block, 16-cycle busy window, latency check.
    stub_len_force = 16;
    stub_dly_force = 0;
    lat_check      = 1'b1;
    send_full(64'haaaa_aaaa_aaaa_aaaa, 1'b0, 64'd0);
    send_last(rnd64(), 6'd10, 2);
    lat_check      = 1'b0;
    stub_len_force = 0;
    stub_dly_force = -1;

    // Chaining with a known first ciphertext.
    send_full(rnd64(), 1'b1, 64'h1234_5678_9abc_def0);
    send_full(rnd64(), 1'b0, 64'd0);
    send_last(rnd64(), 6'd33, 1);

    // Long final-block hold.
    send_last(64'h5555_5555_5555_5555, 6'd63, 40);

    // Enable toggling every cycle, then random enables.
    en_mode = 2;
    send_full(rnd64(), 1'b0, 64'd0);
    send_last(rnd64(), 6'd7, 2);
    en_mode = 1;
    send_full(rnd64(), 1'b0, 64'd0);
    send_full(rnd64(), 1'b0, 64'd0);
    send_last(rnd64(), 6'd20, 3);
    en_mode = 0;

    // Empty final block still needs the handshake.
    send_last(rnd64(), 6'd0, 3);

    // Stray last_ack while idle must not move the FSM.
    ack_mode = 2;
    repeat (4) begin
      step();
      chk("stray_ack_ready", 64'(blk_ready), 64'd1);
      chk("stray_ack_filled", 64'(last_filled), 64'd0);
    end
    ack_mode = 0;

    reset_in_wait();

    for (int m = 0; m < 30; m++) begin
      int nf;
      en_mode = $urandom_range(0, 1);
      nf = $urandom_range(0, 4);
      for (int i = 0; i < nf; i++) send_full(rnd64(), 1'b0, 64'd0);
      send_last(rnd64(), 6'($urandom_range(0, 63)), $urandom_range(0, 5));
    end
    en_mode = 0;
    repeat (40) step();

    chk("start_q_empty", 64'(start_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_sign_ctrl.md
DES_SIGN_CTRL -- requirements
Module: des_sign_ctrl

Interface
REQ-001 Parameter IV, default 64'h0000_0000_0000_0000, initial CBC chaining value.
REQ-002 Parameter CNT_W, default 16, width of block counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clk_en  in  1  global enable; state/outputs update only when 1.
REQ-006 blk_in  in  64  message block from requester.
REQ-007 blk_valid  in  1  blk_in/blk_last/blk_size valid.
REQ-008 blk_last  in  1  block is final (partial) block.
REQ-009 blk_size  in  6  valid bits of final block, 0 = none.
REQ-010 blk_ready  out  1  controller accepts block this cycle.
REQ-011 des_data  out  64  DES core plaintext (blk_in XOR chain).
REQ-012 des_start  out  1  one-cycle DES start pulse.
REQ-013 des_busy  in  1  DES core busy.
REQ-014 des_out  in  64  DES core result, valid when des_busy=0 after start.
REQ-015 ser_des_in  out  64  ciphertext to serializer.
REQ-016 ser_des_wr  out  1  one-cycle write pulse to serializer.
REQ-017 last_in  out  64  final block to serializer.
REQ-018 last_size  out  6  final block size to serializer.
REQ-019 last_filled  out  1  final block pending for serializer.
REQ-020 last_ack  in  1  serializer consumed final block.
REQ-021 done  out  1  one-cycle pulse, message complete.
REQ-022 blk_cnt  out  CNT_W  DES blocks processed in current message.

Function
REQ-023 FSM states SHALL be IDLE, START, ARM, WAIT, EMIT, LASTW, FIN.
REQ-024 blk_ready SHALL equal (state==IDLE) AND clk_en, combinationally.
REQ-025 IDLE, blk_valid&blk_ready&!blk_last: des_data <= blk_in XOR chain; -> START.
REQ-026 IDLE, blk_valid&blk_ready&blk_last: last_in <= blk_in, last_size <= blk_size, last_filled <= 1; -> LASTW.
REQ-027 START: des_start=1 for exactly this cycle; -> ARM.
REQ-028 ARM: stay until des_busy=1, then -> WAIT.
REQ-029 WAIT: stay while des_busy=1; on des_busy=0 -> EMIT.
REQ-030 EMIT: ser_des_in <= des_out, chain <= des_out, ser_des_wr=1 one cycle, blk_cnt+1 (saturating at all-ones); -> IDLE.
REQ-031 LASTW: hold last_* stable; on last_ack=1 clear last_filled -> FIN.
REQ-032 FIN: done=1 one cycle, chain <= IV, blk_cnt <= 0; -> IDLE.
REQ-033 Latency block accept -> ser_des_wr SHALL be 3 + DES busy-window cycles (START, ARM ≥1, WAIT ≥1, EMIT).
REQ-034 blk_valid outside IDLE SHALL be ignored; requester holds it.
REQ-035 last_ack outside LASTW SHALL be ignored.
REQ-036 clk_en=0 SHALL freeze state, all registers, and force des_start, ser_des_wr, done to 0; pulses resume on next enabled cycle.
REQ-037 blk_size=0 final block SHALL still use LASTW handshake.
REQ-038 des_data SHALL stay stable from START until EMIT.

Reset
REQ-039 rst=1 SHALL override all other inputs including clk_en.
REQ-040 On reset: state IDLE, des_start/ser_des_wr/done/last_filled 0, des_data/ser_des_in/last_in 0, last_size 0, chain IV, blk_cnt 0.
REQ-041 Reset mid-operation (any state) SHALL abandon message; no pulse emitted on the reset cycle or the cycle after.

Verification
REQ-042 Single block aaaa..aa, IV=0, busy high 16 cycles -> one des_start, des_data=aaaa..aa, ser_des_wr with ser_des_in=des_out, blk_cnt=1.
REQ-043 Two blocks, des_out #1=1234_5678_9abc_def0 -> second des_data=blk_in XOR 1234_5678_9abc_def0.
REQ-044 Final block 5555..55, blk_size=63, last_ack after 40 cycles -> last_filled high 40 cycles, then done pulse, blk_cnt=0, chain=IV.
REQ-045 clk_en toggled 0/1 during START and EMIT -> exactly one des_start and one ser_des_wr, each in an enabled cycle.
REQ-046 rst in WAIT -> outputs at reset values next cycle; late des_busy fall produces no ser_des_wr.
REQ-047 blk_valid held during WAIT, stray last_ack in IDLE -> blk_ready=0 until IDLE, no state change from last_ack.
